// File: rtl/coeff_energy_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cost_pkg
// Brief    : Shared constants, FSM encoding and width helper for the
//            coefficient energy accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package cost_pkg;

    localparam logic MODE_LUMA   = 1'b0;
    localparam logic MODE_CHROMA = 1'b1;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
    localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;

    // One block's energy: COEFS squares plus a dc square, no overflow possible.
    function automatic int blk_sum_width(input int bit_width, input int coefs);
        return 2 * bit_width + $clog2(coefs) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coeff_energy_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : coeff_energy_acc_if
// Brief    : Job request / result bundle of the coefficient energy engine.
// Revision : 1.0 - initial release
// ============================================================================
interface coeff_energy_acc_if #(
    parameter int BIT_WIDTH  = 16,
    parameter int NUM_BLOCKS = 16,
    parameter int COEFS      = 16,
    parameter int SUM_WIDTH  = 32
);
    logic                                  start;
    logic                                  mode;
    logic [BIT_WIDTH*COEFS*NUM_BLOCKS-1:0] ac;
    logic [BIT_WIDTH*NUM_BLOCKS-1:0]       dc;
    logic                                  busy;
    logic [SUM_WIDTH-1:0]                  sum;
    logic                                  done;

    modport master (output start, mode, ac, dc, input busy, sum, done);
    modport slave  (input start, mode, ac, dc, output busy, sum, done);
endinterface
`default_nettype wire

// File: rtl/coeff_energy_acc_block_sq_sum.sv
`default_nettype none
// ============================================================================
// Module   : block_sq_sum
// Brief    : Squares one block's AC coefficients (and optional DC) and sums
//            them; two registered stages.
// Revision : 1.0 - initial release
// ============================================================================
module block_sq_sum
    import cost_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int COEFS     = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [BIT_WIDTH*COEFS-1:0]                   ac_blk,
    input  logic [BIT_WIDTH-1:0]                         dc_blk,
    input  logic                                         dc_en,
    output logic [blk_sum_width(BIT_WIDTH, COEFS)-1:0]   blk_sum
);
    localparam int BSW  = blk_sum_width(BIT_WIDTH, COEFS);
    localparam int SQ_W = 2 * BIT_WIDTH;

    logic [SQ_W-1:0] sq_d [COEFS];
    logic [SQ_W-1:0] sq_q [COEFS];
    logic [SQ_W-1:0] dc_sq_d, dc_sq_q;
    logic [BSW-1:0]  blk_sum_d, blk_sum_q;

    logic signed [BIT_WIDTH-1:0] dc_s;
    logic signed [SQ_W-1:0]      dc_prod;

    // Signed operands in a 2*BIT_WIDTH context: the most negative input squares exactly.
    for (genvar c = 0; c < COEFS; c++) begin : g_sq
        logic signed [BIT_WIDTH-1:0] coef;
        logic signed [SQ_W-1:0]      prod;
        assign coef    = ac_blk[c*BIT_WIDTH +: BIT_WIDTH];
        assign prod    = coef * coef;
        assign sq_d[c] = prod;
    end

    assign dc_s    = dc_blk;
    assign dc_prod = dc_s * dc_s;

    always_comb begin
        dc_sq_d   = dc_en ? dc_prod : '0;
        blk_sum_d = BSW'(dc_sq_q);
        for (int c = 0; c < COEFS; c++) begin
            blk_sum_d = blk_sum_d + BSW'(sq_q[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COEFS; c++) begin
                sq_q[c] <= '0;
            end
            dc_sq_q   <= '0;
            blk_sum_q <= '0;
        end else begin
            sq_q      <= sq_d;
            dc_sq_q   <= dc_sq_d;
            blk_sum_q <= blk_sum_d;
        end
    end

    assign blk_sum = blk_sum_q;

endmodule
`default_nettype wire

// File: rtl/coeff_energy_acc.sv
`default_nettype none
// ============================================================================
// Module   : coeff_energy_acc
// Brief    : Sum-of-squares energy of a macroblock's quantised coefficients.
//            Optional build macro COEFF_ENERGY_SAT_EN selects a saturating
//            accumulator instead of modulo wrap.
// Revision : 1.0 - initial release
// ============================================================================
module coeff_energy_acc
    import cost_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int NUM_BLOCKS = 16,
    parameter int COEFS      = 16,
    parameter int SUM_WIDTH  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    coeff_energy_acc_if.slave  bus
);
    localparam int BSW   = blk_sum_width(BIT_WIDTH, COEFS);
    localparam int CW    = $clog2(NUM_BLOCKS);
    localparam int EW    = ((SUM_WIDTH > BSW) ? SUM_WIDTH : BSW) + 1;
    localparam int BLK_W = BIT_WIDTH * COEFS;
    localparam int AC_W  = BLK_W * NUM_BLOCKS;
    localparam int DC_W  = BIT_WIDTH * NUM_BLOCKS;
    localparam logic [CW-1:0] LAST_LUMA   = CW'(NUM_BLOCKS - 1);
    localparam logic [CW-1:0] LAST_CHROMA = CW'(NUM_BLOCKS / 2 - 1);

    logic [ST_W-1:0]      state_q, state_d;
    logic [AC_W-1:0]      ac_q, ac_d;
    logic [DC_W-1:0]      dc_q, dc_d;
    logic                 mode_q, mode_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 v1_q, v1_d, v2_q, v2_d;
    logic                 last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
    logic [SUM_WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 last_blk;
    logic [BSW-1:0]       blk_sum;
    logic [EW-1:0]        acc_ext;
    logic [SUM_WIDTH-1:0] acc_add;

    assign accept   = bus.start && (state_q == ST_IDLE);
    assign last_blk = (state_q == ST_RUN) &&
                      (cnt_q == ((mode_q == MODE_CHROMA) ? LAST_CHROMA : LAST_LUMA));

    block_sq_sum #(
        .BIT_WIDTH (BIT_WIDTH),
        .COEFS     (COEFS)
    ) u_block_sq_sum (
        .clk     (clk),
        .rst_n   (rst_n),
        .ac_blk  (ac_q[int'(cnt_q)*BLK_W +: BLK_W]),
        .dc_blk  (dc_q[int'(cnt_q)*BIT_WIDTH +: BIT_WIDTH]),
        .dc_en   (mode_q == MODE_LUMA),
        .blk_sum (blk_sum)
    );

    assign acc_ext = EW'(acc_q) + EW'(blk_sum);
`ifdef COEFF_ENERGY_SAT_EN
    // Once the sum reaches all-ones every further add overflows again, so it sticks.
    assign acc_add = (|acc_ext[EW-1:SUM_WIDTH]) ? '1 : acc_ext[SUM_WIDTH-1:0];
`else
    logic unused_ovf;
    assign unused_ovf = ^acc_ext[EW-1:SUM_WIDTH];
    assign acc_add    = acc_ext[SUM_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept)   state_d = ST_RUN;
            ST_RUN:   if (last_blk) state_d = ST_DRAIN;
            ST_DRAIN: if (last3_q)  state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != ST_IDLE);
        bus.sum  = sum_q;
        bus.done = done_q;
    end

    // Valid and last flags travel alongside the two block_sq_sum stages.
    always_comb begin
        ac_d    = ac_q;
        dc_d    = dc_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        if (accept) begin
            ac_d   = bus.ac;
            dc_d   = bus.dc;
            mode_d = bus.mode;
            acc_d  = '0;
        end else if (v2_q) begin
            acc_d = acc_add;
        end
        if (state_q == ST_RUN) begin
            cnt_d = last_blk ? '0 : cnt_q + CW'(1);
        end
        v1_d    = (state_q == ST_RUN);
        v2_d    = v1_q;
        last1_d = last_blk;
        last2_d = last1_q;
        last3_d = last2_q;
        done_d  = last3_q;
        if (last3_q) begin
            sum_d = acc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_q    <= '0;
            dc_q    <= '0;
            mode_q  <= MODE_LUMA;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            last3_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            ac_q    <= ac_d;
            dc_q    <= dc_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            last1_q <= last1_d;
            last2_q <= last2_d;
            last3_q <= last3_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
        end
    end

endmodule
`default_nettype wire
